// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial adder controller; one half-adder pair + carry flop
//            processes a+b LSB first over WIDTH cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shared 1-bit adder cell: two half adders, carries ORed.
  logic c1, s1, c2, s_bit;
  always_comb begin
    c1    = a_q[0] & b_q[0];
    s1    = a_q[0] ^ b_q[0];
    c2    = s1 & carry_q;
    s_bit = s1 ^ carry_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d = c1 | c2;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Result is published only here; it stays put until the next DONE.
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c1 | c2;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Self-checking bench for serial_add_ctrl, directed plus random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
  localparam int LIMIT = WIDTH + 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer addition, carry is the extra top bit.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and observe it; returns raw observations only.
  // inj > 0 pulses start with all-ones operands on that RUN cycle.
  // Returns positioned inside the done cycle (or after the bound expires).
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input int inj,
                       output int lat, output int busy_cnt, output int overlap,
                       output int sum_moved, output logic [WIDTH-1:0] s_o, output logic c_o);
    logic [WIDTH-1:0] s_prev;
    logic             c_prev;
    s_prev = sum;
    c_prev = cout;
    start = 1'b1; a = xa; b = xb;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; busy_cnt = 0; overlap = 0; sum_moved = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy === 1'b1) busy_cnt++;
      if (sum !== s_prev || cout !== c_prev) sum_moved++;
      if (lat == inj) begin
        start = 1'b1; a = '1; b = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    if (busy === 1'b1 && done === 1'b1) overlap++;
    s_o = sum;
    c_o = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    checks++;
    if ({busy, done, cout, sum} !== {3'b000, {WIDTH{1'b0}}}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, required 0 0 0 00", busy, done, cout, sum);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s;
    logic c;
    do_op(8'h3C, 8'h0F, 0, lat, bc, ov, mv, s, c);
    checks++;
    if (lat != WIDTH + 1 || bc != WIDTH) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d busy %0d cycles, required %0d and %0d", lat, bc, WIDTH + 1, WIDTH);
    end
    checks++;
    if ({c, s} !== 9'h04B) begin
      errors++;
      $display("FAIL basic_sum: got %b/%h, required 0/4b", c, s);
    end
    checks++;
    if (mv != 0 || ov != 0) begin
      errors++;
      $display("FAIL basic_stable: sum moved %0d cycles, busy&done %0d, required 0 0", mv, ov);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h4B) begin
      errors++;
      $display("FAIL basic_idle_hold: busy=%b done=%b sum=%h, required 0 0 4b", busy, done, sum);
    end
  endtask

  task automatic test_overflow();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s;
    logic c;
    do_op(8'hFF, 8'h01, 0, lat, bc, ov, mv, s, c);
    tick();
    checks++;
    if ({c, s} !== 9'h100) begin
      errors++;
      $display("FAIL ovf_ff_01: got %b/%h, required 1/00", c, s);
    end
    do_op(8'h80, 8'h80, 0, lat, bc, ov, mv, s, c);
    tick();
    checks++;
    if ({c, s} !== 9'h100) begin
      errors++;
      $display("FAIL ovf_80_80: got %b/%h, required 1/00", c, s);
    end
  endtask

  task automatic test_start_in_run();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s;
    logic c;
    do_op(8'h12, 8'h34, 3, lat, bc, ov, mv, s, c);
    checks++;
    if ({c, s} !== 9'h046 || lat != WIDTH + 1) begin
      errors++;
      $display("FAIL start_in_run: got %b/%h lat %0d, required 0/46 lat %0d", c, s, lat, WIDTH + 1);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run_queued: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s;
    logic c;
    start = 1'b1; a = 8'h77; b = 8'h66;
    tick();
    start = 1'b0;
    tick(); tick(); tick();   // now in RUN cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== {3'b000, {WIDTH{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b done=%b cout=%b sum=%h, required 0 0 0 00", busy, done, cout, sum);
    end
    do_op(8'h01, 8'h01, 0, lat, bc, ov, mv, s, c);
    tick();
    checks++;
    if ({c, s} !== 9'h002 || lat != WIDTH + 1) begin
      errors++;
      $display("FAIL rst_then_run: got %b/%h lat %0d, required 0/02 lat %0d", c, s, lat, WIDTH + 1);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s;
    logic c;
    do_op(8'h10, 8'h20, 0, lat, bc, ov, mv, s, c);
    // Still in the done cycle: the next do_op asserts start here.
    do_op(8'hAA, 8'h55, 0, lat, bc, ov, mv, s, c);
    checks++;
    if (lat != WIDTH + 1 || bc != WIDTH) begin
      errors++;
      $display("FAIL b2b_latency: done at %0d busy %0d, required %0d and %0d", lat, bc, WIDTH + 1, WIDTH);
    end
    checks++;
    if ({c, s} !== 9'h0FF) begin
      errors++;
      $display("FAIL b2b_sum: got %b/%h, required 0/ff", c, s);
    end
    checks++;
    if (mv != 0) begin
      errors++;
      $display("FAIL b2b_hold: previous sum moved %0d cycles, required 0", mv);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bc, ov, mv;
    logic [WIDTH-1:0] s, xa, xb;
    logic c;
    logic [WIDTH:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      xa = $urandom; xb = $urandom;
      exp_v = ref_add(xa, xb);
      do_op(xa, xb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0,
            lat, bc, ov, mv, s, c);
      checks++;
      if ({c, s} !== exp_v || lat != WIDTH + 1 || bc != WIDTH || ov != 0 || mv != 0) begin
        errors++;
        $display("FAIL random[%0d] %h+%h: got %b/%h lat %0d busy %0d ov %0d mv %0d, required %b/%h lat %0d busy %0d",
                 i, xa, xb, c, s, lat, bc, ov, mv, exp_v[WIDTH], exp_v[WIDTH-1:0], WIDTH + 1, WIDTH);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
